// File: rtl/snake_pkg.sv
// Shared constants for the snake board: cell codes, board geometry, colours,
// 640x480@60 VGA timing, and the flag bundle carried down the scan-out pipe.
package snake_pkg;

   localparam int WIDTH      = 32;
   localparam int HEIGHT     = 16;
   localparam int CELL_PX    = 16;
   localparam int CELL_SHIFT = 4;

   typedef enum logic [3:0] {
      EMPTY = 4'b0000,
      RIGHT = 4'b0001,
      UP    = 4'b0010,
      LEFT  = 4'b0100,
      DOWN  = 4'b1000,
      APPLE = 4'b1111
   } cell_t;

   localparam logic [7:0] BLACK  = 8'b000_000_00;
   localparam logic [7:0] GREY   = 8'b010_010_01;
   localparam logic [7:0] GREEN  = 8'b000_111_00;
   localparam logic [7:0] YELLOW = 8'b111_111_00;
   localparam logic [7:0] RED    = 8'b111_000_00;
   localparam logic [7:0] WHITE  = 8'b111_111_11;

   localparam int H_VIS        = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 751;
   localparam int H_TOTAL      = 800;
   localparam int V_VIS        = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 491;
   localparam int V_TOTAL      = 525;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic vis;
      logic board;
      logic frame;
   } scan_flags_t;

   localparam scan_flags_t FLAGS_RST = '{hsync: 1'b1, vsync: 1'b1, vis: 1'b0,
                                         board: 1'b0, frame: 1'b0};

   function automatic logic [7:0] cell_colour(input logic [3:0] code,
                                              input logic       game_over);
      logic [7:0] col;
      case (code)
         EMPTY:                 col = BLACK;
         APPLE:                 col = RED;
         RIGHT, UP, LEFT, DOWN: col = game_over ? YELLOW : GREEN;
         default:               col = WHITE;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, h/v scan counters and the registered stage-0 sync/visible
// flags for 640x480@60.
module vga_timing
   import snake_pkg::*;
#(
   parameter int PIX_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       vis,
   output logic       frame
);

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             hsync_raw_q, hsync_raw_d;
   logic             vsync_raw_q, vsync_raw_d;
   logic             vis_q, vis_d;
   logic             frame_q, frame_d;
   logic             tick;
   logic             line_end;

   always_comb begin
      tick     = (div_q == DIV_W'(PIX_DIV - 1));
      line_end = (h_q == 10'(H_TOTAL - 1));
      div_d    = tick ? '0 : div_q + DIV_W'(1);
      h_d      = h_q;
      v_d      = v_q;
      if (tick) begin
         h_d = line_end ? '0 : h_q + 10'd1;
         if (line_end) begin
            v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
         end
      end
   end

   // Flags describe the counters as they are now; they land one clk later.
   always_comb begin
      hsync_raw_d = !((h_q >= 10'(H_SYNC_START)) && (h_q <= 10'(H_SYNC_END)));
      vsync_raw_d = !((v_q >= 10'(V_SYNC_START)) && (v_q <= 10'(V_SYNC_END)));
      vis_d       = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
      frame_d     = (h_q == '0) && (v_q == '0) && (div_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q       <= '0;
         h_q         <= '0;
         v_q         <= '0;
         hsync_raw_q <= 1'b1;
         vsync_raw_q <= 1'b1;
         vis_q       <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         div_q       <= div_d;
         h_q         <= h_d;
         v_q         <= v_d;
         hsync_raw_q <= hsync_raw_d;
         vsync_raw_q <= vsync_raw_d;
         vis_q       <= vis_d;
         frame_q     <= frame_d;
      end
   end

   assign h_cnt     = h_q;
   assign v_cnt     = v_q;
   assign hsync_raw = hsync_raw_q;
   assign vsync_raw = vsync_raw_q;
   assign vis       = vis_q;
   assign frame     = frame_q;

endmodule

// File: rtl/board_scanout.sv
// Scan-out engine: reads the board RAM through its read port, aligns the
// sync/visible flags with the RAM latency and drives VGA sync and RRRGGGBB.
module board_scanout
   import snake_pkg::*;
#(
   parameter int PIX_DIV  = 2,
   parameter int RAM_LAT  = 2,
   parameter int X_OFFSET = 64,
   parameter int Y_OFFSET = 112
) (
   input  logic       clk,
   input  logic       rst,
   output logic [4:0] rd_x,
   output logic [3:0] rd_y,
   output logic       rd_en,
   input  logic [3:0] rd_data,
   input  logic       game_over,
   output logic       hsync,
   output logic       vsync,
   output logic [7:0] rgb,
   output logic       frame_start
);

   localparam logic [9:0] X_LO = 10'(X_OFFSET);
   localparam logic [9:0] X_HI = 10'(X_OFFSET + WIDTH * CELL_PX);
   localparam logic [9:0] Y_LO = 10'(Y_OFFSET);
   localparam logic [9:0] Y_HI = 10'(Y_OFFSET + HEIGHT * CELL_PX);

   logic [9:0]  h_cnt, v_cnt;
   logic        hsync_raw, vsync_raw, vis, frame;

   logic        board_q, board_d;
   logic        rd_en_q, rd_en_d;
   logic [4:0]  rd_x_q, rd_x_d;
   logic [3:0]  rd_y_q, rd_y_d;

   scan_flags_t s0;
   scan_flags_t dly_q [RAM_LAT];
   scan_flags_t dly_d [RAM_LAT];
   scan_flags_t fl;

   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic [7:0]  rgb_q, rgb_d;
   logic        frame_start_q, frame_start_d;

   vga_timing #(
      .PIX_DIV (PIX_DIV)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .vis       (vis),
      .frame     (frame)
   );

   // Stage 0 address generation, registered alongside the timing flags.
   always_comb begin
      board_d = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                (v_cnt >= Y_LO) && (v_cnt < Y_HI);
      rd_en_d = board_d;
      rd_x_d  = board_d ? 5'((h_cnt - X_LO) >> CELL_SHIFT) : rd_x_q;
      rd_y_d  = board_d ? 4'((v_cnt - Y_LO) >> CELL_SHIFT) : rd_y_q;
   end

   always_comb begin
      s0 = '{hsync: hsync_raw, vsync: vsync_raw, vis: vis,
             board: board_q, frame: frame};
      dly_d[0] = s0;
      for (int i = 1; i < RAM_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   // fl is aligned with rd_data for the same pixel.
   always_comb begin
      fl            = dly_q[RAM_LAT-1];
      hsync_d       = fl.hsync;
      vsync_d       = fl.vsync;
      frame_start_d = fl.frame;
      if (!fl.vis) begin
         rgb_d = BLACK;
      end else if (!fl.board) begin
         rgb_d = GREY;
      end else begin
         rgb_d = cell_colour(rd_data, game_over);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         board_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_x_q        <= '0;
         rd_y_q        <= '0;
         for (int i = 0; i < RAM_LAT; i++) begin
            dly_q[i] <= FLAGS_RST;
         end
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= BLACK;
         frame_start_q <= 1'b0;
      end else begin
         board_q       <= board_d;
         rd_en_q       <= rd_en_d;
         rd_x_q        <= rd_x_d;
         rd_y_q        <= rd_y_d;
         dly_q         <= dly_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign rd_x        = rd_x_q;
   assign rd_y        = rd_y_q;
   assign rd_en       = rd_en_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule
